// File: rtl/intc_pkg.sv
// Shared types and defaults for the interrupt responder.
// Edge versus level capture is selected in intc_responder by INTC_EDGE_EN.
package intc_pkg;

   localparam int unsigned NUM_SRC_DEF = 4;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StReq     = 2'd1,
      StService = 2'd2
   } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Find-first-set over the enabled pending vector; bit 0 has the highest priority.
module intc_prio_enc #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] vec,
   output logic               any,
   output logic [ID_W-1:0]    idx
);

   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (vec[i] && !any) begin
            any = 1'b1;
            idx = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/intc_responder.sv
// Interrupt responder: pending capture, enable mask, lowest-index select, req/ack/done handshake.
// Define INTC_EDGE_EN for edge capture; the default build registers the source levels.
module intc_responder
   import intc_pkg::*;
#(
   parameter int unsigned NUM_SRC = NUM_SRC_DEF,
   parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src,
   input  logic               mask_wr,
   input  logic [NUM_SRC-1:0] mask_wdata,
   input  logic               irq_ack,
   input  logic               irq_done,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] mask,
   output logic               in_service
);

   intc_state_e        state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] mask_q;
   logic               sel_any;
   logic [ID_W-1:0]    sel_idx;

   intc_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio_enc (
      .vec (pending_q & mask_q),
      .any (sel_any),
      .idx (sel_idx)
   );

`ifdef INTC_EDGE_EN
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] clr;

   always_comb begin
      clr = '0;
      if (state_q == StReq && irq_ack) begin
         clr[id_q] = 1'b1;
      end
   end

   // A new edge is OR-ed in after the clear, so set wins on the same bit.
   assign pending_d = (pending_q & ~clr) | (src & ~src_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         src_q <= '0;
      end else begin
         src_q <= src;
      end
   end
`else
   assign pending_d = src;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         mask_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (mask_wr) begin
            mask_q <= mask_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
      end
   end

   // Once presented, a request is held until ack regardless of mask or new arrivals.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      case (state_q)
         StIdle: begin
            if (sel_any) begin
               id_d    = sel_idx;
               state_d = StReq;
            end
         end
         StReq: begin
            if (irq_ack) begin
               state_d = StService;
            end
         end
         StService: begin
            if (irq_done) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign irq_req    = (state_q == StReq);
   assign in_service = (state_q == StService);
   assign irq_id     = id_q;
   assign pending    = pending_q;
   assign mask       = mask_q;

endmodule

// File: doc/intc_responder.md
# intc_responder

Interrupt responder that sits between the processor core and the peripheral interrupt sources, including the watchdog timer's `interrupt` output. It captures requests into a pending register, applies a core-writable enable mask, and picks the lowest-index enabled source. It presents that source to the core through an `irq_req`/`irq_ack` handshake, then stays in service until the core signals completion with `irq_done`.

## Interface
- `NUM_SRC`, default 4: number of interrupt source lines, 2..32.
- `ID_W`, default `$clog2(NUM_SRC)`: width of `irq_id`. Not overridden.

Ports:
- `clk` in 1: single clock. Every register samples on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `src` in NUM_SRC: interrupt source lines; the watchdog drives bit 0.
- `mask_wr` in 1: one-cycle strobe that loads `mask_wdata` into the mask.
- `mask_wdata` in NUM_SRC: new mask value; 1 means enabled.
- `irq_ack` in 1: core accepts the presented request.
- `irq_done` in 1: core finished the handler (mret).
- `irq_req` out 1: request to the core.
- `irq_id` out ID_W: index of the presented source.
- `pending` out NUM_SRC: pending register.
- `mask` out NUM_SRC: mask register.
- `in_service` out 1: high while in SERVICE.

## Operation
- Reset values:
  - `irq_req`=0, `irq_id`=0, `pending`=0, `mask`=0 (all sources disabled), `in_service`=0.
  - Internal `src_q`=0, state=IDLE.
- Capture (edge mode):
  - `pending[i]` sets when `src[i] & ~src_q[i]`.
  - A source already high when reset releases counts as an edge.
  - A held level does not re-set the pending bit after ack.
- Mask:
  - `mask_wr` loads `mask` at the edge.
  - Masking never clears `pending`; a masked pending bit stays latched and fires once unmasked.
- State machine:
  - IDLE: if `pending & mask` is nonzero, latch `irq_id` = lowest set index and go to REQ.
  - REQ: `irq_req`=1 and `irq_id` held stable.
    - On `irq_ack`, clear `pending[irq_id]` and go to SERVICE.
    - The request is never withdrawn, even if the mask changes or a lower-index source arrives.
  - SERVICE: `irq_req`=0, `in_service`=1. On `irq_done`, go to IDLE. No nesting.
- Ignored inputs:
  - `irq_ack` outside REQ.
  - `irq_done` outside SERVICE.
- Same cycle, same bit, new edge and ack clear: set wins, so the bit stays pending.
- `irq_ack` and `irq_done` together in REQ: only the ack is taken; the FSM ends in SERVICE.

## Timing
- Request latency:
  - `src[i]` first sampled high at edge E0 makes `pending[i]` visible after E0.
  - `irq_req` is visible after E1 (2 cycles), given mask bit set and FSM in IDLE.
- Ack is sampled at edge Ea. After Ea: `irq_req`=0, `in_service`=1, pending bit cleared.
- Done is sampled at edge Ed. After Ed: IDLE. The earliest next `irq_req` is after Ed+1, so there is at least one low cycle between requests.
- `irq_id` is valid only while `irq_req`=1. It holds its last value otherwise.
- `rst` asserted in any state forces all reset values after the next edge. An in-flight request or service is abandoned.
- `mask_wr` concurrent with the IDLE decision: the decision uses the old mask; the new mask applies from the next cycle.

## Configuration
- Macro: `INTC_EDGE_EN`.
- Defined: edge capture exactly as described above.
- Undefined: level mode.
  - `pending` = `src` registered each cycle.
  - `irq_ack` does not clear `pending`.
  - The source must deassert before `irq_done`, otherwise it re-requests immediately.

## Structure
- Package `intc_pkg`:
  - State encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - Default `NUM_SRC`.
- Sub-module `intc_prio_enc`: combinational find-first-set over `pending & mask`. Outputs `any` and `idx[ID_W-1:0]`.

## Test plan
- Edge to request:
  - Stimulus: reset, write mask=4'b0001, pulse `src[0]` high at E0.
  - Response: `irq_req`=1 with `irq_id`=0 after E1; ack → `pending`=0, `in_service`=1; done → IDLE.
- Priority:
  - Stimulus: mask=4'b1111, `src[3]` and `src[1]` rise in the same cycle.
  - Response: `irq_id`=1 first. After done plus one cycle, `irq_id`=3.
- Masked latch:
  - Stimulus: mask=0, `src[2]` edge.
  - Response: `pending`=4'b0100 and `irq_req` stays 0 for 10 cycles. Write mask=4'b0100 → `irq_req` after 1 cycle, `irq_id`=2.
- Watchdog hold (edge mode):
  - Stimulus: `src[0]` held high for 50 cycles across ack/done.
  - Response: exactly one request.
- Simultaneous set/clear:
  - Stimulus: ack of id 0 in the same cycle as a fresh `src[0]` edge.
  - Response: `pending[0]` stays 1; a second request follows after done.
- Reset mid-service:
  - Stimulus: `rst` pulsed in SERVICE.
  - Response: after the edge, `in_service`=0, `mask`=0, `pending`=0, `irq_req`=0. A late `irq_done` is ignored.
